// File: rtl/pa_SnnAccelerator.sv
// Shared definitions for the SNN accelerator control path: inferred-digit
// width, batch sequencer defaults and the sequencer state encoding.
package pa_SnnAccelerator;

  localparam int M                  = 4;
  localparam int RES_DEPTH_DEF      = 16;
  localparam int TIMEOUT_CYCLES_DEF = 1048576;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_IMG = 3'd1,
    LAUNCH   = 3'd2,
    RUN      = 3'd3,
    STORE    = 3'd4,
    DONE     = 3'd5
  } seq_state_e;

  // True when v is a power of two and at least 2.
  function automatic logic is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/snn_result_fifo.sv
// First-word-fall-through result FIFO. The head word, valid flag and
// occupancy are all registered so the consumer sees clean outputs.
module snn_result_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic          push_ready_o,
  output logic [W-1:0]  data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, valid_d;
  logic          pop_s;
  logic          push_s;

  // A pop on an empty FIFO is dropped; a full FIFO still accepts a push
  // when the head leaves in the same cycle.
  always_comb begin
    pop_s        = pop_i && (count_q != {CW{1'b0}});
    push_ready_o = (count_q != CW'(DEPTH)) || pop_i;
    push_s       = push_i && push_ready_o;
  end

  // Next pointers, occupancy and the head word that will be presented.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(push_s) - CW'(pop_s);
    valid_d  = (count_d != {CW{1'b0}});
    if (count_d == {CW{1'b0}}) begin
      head_d = {W{1'b0}};
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      // The word being written becomes the head (FIFO was empty after the pop).
      head_d = data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer, occupancy and output registers with synchronous flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      head_q   <= {W{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/snn_batch_sequencer.sv
// Batch sequencer for the SNN coprocessor: launches each image, waits for
// encoder/decoder completion or a per-image timeout, and queues the results.
// Optional macro SNN_SEQ_LATENCY_EN adds a saturating RUN-latency field to
// every result word.
module snn_batch_sequencer #(
  parameter int M              = pa_SnnAccelerator::M,
  parameter int BATCH_BITS     = 8,
  parameter int RES_DEPTH      = pa_SnnAccelerator::RES_DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = pa_SnnAccelerator::TIMEOUT_CYCLES_DEF,
  parameter int LAT_BITS       = 24,
`ifdef SNN_SEQ_LATENCY_EN
  localparam int RW            = LAT_BITS + M + 1,
`else
  localparam int RW            = M + 1,
`endif
  localparam int CW            = $clog2(RES_DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [BATCH_BITS-1:0] BATCH_LEN,
  input  logic                  IMG_AVAIL,
  output logic                  IMG_TAKE,
  output logic                  NEW_IMAGE,
  input  logic                  ENCODER_RDY,
  input  logic                  DECODER_RDY,
  input  logic [M-1:0]          INFERED_DIGIT,
  output logic [RW-1:0]         RES_DATA,
  output logic                  RES_VALID,
  input  logic                  RES_POP,
  output logic [CW-1:0]         RES_COUNT,
  output logic                  BUSY,
  output logic [BATCH_BITS-1:0] DONE_COUNT,
  output logic                  TIMEOUT_ERR,
  output logic                  IRQ,
  input  logic                  IRQ_CLR
);

  import pa_SnnAccelerator::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  if (!is_pow2(RES_DEPTH) || (LAT_BITS < 1) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("snn_batch_sequencer: unsupported parameter combination");
  end

  seq_state_e            state_q, state_d;
  logic [BATCH_BITS-1:0] len_q, len_d;
  logic [BATCH_BITS-1:0] done_q, done_d;
  logic [TW-1:0]         cyc_q, cyc_d;
  logic                  busy_seen_q, busy_seen_d;
  logic [M-1:0]          digit_q, digit_d;
  logic                  flag_q, flag_d;
  logic                  terr_q, terr_d;
  logic                  irq_q, irq_d;
  logic                  new_image_q, new_image_d;
  logic                  busy_q, busy_d;

  logic                  start_ok_s;
  logic                  ready_s;
  logic                  complete_s;
  logic                  tmo_s;
  logic                  push_s;
  logic                  push_ready_s;
  logic [BATCH_BITS-1:0] done_inc_s;
  logic [RW-1:0]         push_data_s;

  // Qualified events seen by the FSM and the datapath this cycle.
  always_comb begin
    start_ok_s = START && !ABORT && ((state_q == IDLE) || (state_q == DONE)) &&
                 (BATCH_LEN != {BATCH_BITS{1'b0}});
    ready_s    = ENCODER_RDY && DECODER_RDY;
    complete_s = (state_q == RUN) && busy_seen_q && ready_s;
    tmo_s      = (state_q == RUN) && !complete_s && (cyc_q == TMAX);
    push_s     = (state_q == STORE) && !ABORT && push_ready_s;
    done_inc_s = done_q + BATCH_BITS'(1);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ABORT overrides every transition.
  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok_s) state_d = WAIT_IMG;
          else            state_d = state_q;
        end
        WAIT_IMG: begin
          if (IMG_AVAIL) state_d = LAUNCH;
          else           state_d = WAIT_IMG;
        end
        LAUNCH: state_d = RUN;
        RUN: begin
          if (complete_s || tmo_s) state_d = STORE;
          else                     state_d = RUN;
        end
        STORE: begin
          if (!push_s)                  state_d = STORE;
          else if (done_inc_s == len_q) state_d = DONE;
          else                          state_d = WAIT_IMG;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values; outputs follow the next state so they
  // line up with the state they describe.
  always_comb begin
    len_d       = start_ok_s ? BATCH_LEN : len_q;
    cyc_d       = cyc_q;
    busy_seen_d = busy_seen_q;
    digit_d     = digit_q;
    flag_d      = flag_q;
    if (state_q == LAUNCH) begin
      cyc_d       = {TW{1'b0}};
      busy_seen_d = 1'b0;
    end else if (state_q == RUN) begin
      cyc_d       = cyc_q + TW'(1);
      busy_seen_d = busy_seen_q || !ready_s;
    end else begin
      cyc_d       = cyc_q;
      busy_seen_d = busy_seen_q;
    end
    if (complete_s) begin
      digit_d = INFERED_DIGIT;
      flag_d  = 1'b0;
    end else if (tmo_s) begin
      digit_d = {M{1'b0}};
      flag_d  = 1'b1;
    end else begin
      digit_d = digit_q;
      flag_d  = flag_q;
    end
    if (start_ok_s)  done_d = {BATCH_BITS{1'b0}};
    else if (push_s) done_d = done_inc_s;
    else             done_d = done_q;
    if (start_ok_s)          terr_d = 1'b0;
    else if (tmo_s && !ABORT) terr_d = 1'b1;
    else                     terr_d = terr_q;
    // Entering DONE beats a simultaneous clear.
    if ((state_d == DONE) && (state_q == STORE)) irq_d = 1'b1;
    else if (IRQ_CLR || start_ok_s)             irq_d = 1'b0;
    else                                        irq_d = irq_q;
    new_image_d = (state_d == LAUNCH);
    busy_d      = (state_d != IDLE) && (state_d != DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q       <= {BATCH_BITS{1'b0}};
      done_q      <= {BATCH_BITS{1'b0}};
      cyc_q       <= {TW{1'b0}};
      busy_seen_q <= 1'b0;
      digit_q     <= {M{1'b0}};
      flag_q      <= 1'b0;
      terr_q      <= 1'b0;
      irq_q       <= 1'b0;
      new_image_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      len_q       <= len_d;
      done_q      <= done_d;
      cyc_q       <= cyc_d;
      busy_seen_q <= busy_seen_d;
      digit_q     <= digit_d;
      flag_q      <= flag_d;
      terr_q      <= terr_d;
      irq_q       <= irq_d;
      new_image_q <= new_image_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SNN_SEQ_LATENCY_EN
  logic [LAT_BITS-1:0] lat_q, lat_d;
  logic [LAT_BITS-1:0] lat_cap_q, lat_cap_d;
  logic [LAT_BITS-1:0] lat_inc_s;

  // Saturating RUN-cycle count; the value including the exit cycle is kept.
  always_comb begin
    lat_inc_s = (lat_q == {LAT_BITS{1'b1}}) ? lat_q : (lat_q + LAT_BITS'(1));
    if (state_q == LAUNCH)   lat_d = {LAT_BITS{1'b0}};
    else if (state_q == RUN) lat_d = lat_inc_s;
    else                     lat_d = lat_q;
    if (complete_s || tmo_s) lat_cap_d = lat_inc_s;
    else                     lat_cap_d = lat_cap_q;
  end

  // Latency registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lat_q     <= {LAT_BITS{1'b0}};
      lat_cap_q <= {LAT_BITS{1'b0}};
    end else begin
      lat_q     <= lat_d;
      lat_cap_q <= lat_cap_d;
    end
  end

  assign push_data_s = {lat_cap_q, flag_q, digit_q};
`else
  assign push_data_s = {flag_q, digit_q};
`endif

  snn_result_fifo #(
    .W     (RW),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk_i        (CLK),
    .rst_i        (RST),
    .push_i       (push_s),
    .data_i       (push_data_s),
    .pop_i        (RES_POP),
    .push_ready_o (push_ready_s),
    .data_o       (RES_DATA),
    .valid_o      (RES_VALID),
    .count_o      (RES_COUNT)
  );

  assign NEW_IMAGE   = new_image_q;
  assign IMG_TAKE    = new_image_q;
  assign BUSY        = busy_q;
  assign DONE_COUNT  = done_q;
  assign TIMEOUT_ERR = terr_q;
  assign IRQ         = irq_q;

endmodule

// File: tb/tb_snn_batch_sequencer.sv
// Self-checking bench for snn_batch_sequencer (small FIFO and timeout so the
// back-pressure and timeout corners are reachable quickly).
module tb_snn_batch_sequencer;

  localparam int M   = 4;
  localparam int BB  = 8;
  localparam int DEP = 4;
  localparam int TMO = 64;
  localparam int LB  = 24;
`ifdef SNN_SEQ_LATENCY_EN
  localparam int RW  = LB + M + 1;
`else
  localparam int RW  = M + 1;
`endif
  localparam int CW  = $clog2(DEP) + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [BB-1:0] BATCH_LEN = '0;
  logic          IMG_AVAIL = 1'b1;
  logic          IMG_TAKE, NEW_IMAGE;
  logic          ENCODER_RDY = 1'b1;
  logic          DECODER_RDY = 1'b1;
  logic [M-1:0]  INFERED_DIGIT = '0;
  logic [RW-1:0] RES_DATA;
  logic          RES_VALID;
  logic          RES_POP = 1'b0;
  logic [CW-1:0] RES_COUNT;
  logic          BUSY;
  logic [BB-1:0] DONE_COUNT;
  logic          TIMEOUT_ERR, IRQ;
  logic          IRQ_CLR = 1'b0;

  always #5 CLK = ~CLK;

  snn_batch_sequencer #(
    .M(M), .BATCH_BITS(BB), .RES_DEPTH(DEP), .TIMEOUT_CYCLES(TMO), .LAT_BITS(LB)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .BATCH_LEN(BATCH_LEN),
    .IMG_AVAIL(IMG_AVAIL), .IMG_TAKE(IMG_TAKE), .NEW_IMAGE(NEW_IMAGE),
    .ENCODER_RDY(ENCODER_RDY), .DECODER_RDY(DECODER_RDY),
    .INFERED_DIGIT(INFERED_DIGIT), .RES_DATA(RES_DATA), .RES_VALID(RES_VALID),
    .RES_POP(RES_POP), .RES_COUNT(RES_COUNT), .BUSY(BUSY),
    .DONE_COUNT(DONE_COUNT), .TIMEOUT_ERR(TIMEOUT_ERR), .IRQ(IRQ),
    .IRQ_CLR(IRQ_CLR)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- engine model: encoder/decoder pair ----------------
  // delay d (>=3): ready drops at the NEW_IMAGE cycle and rises d-1 cycles
  // into RUN; delay 0: ready never returns.
  typedef struct { int delay; int digit; } job_t;
  job_t jobs[$];
  job_t cur;
  int   cd   = 0;
  int   nimg = 0;

  always @(negedge CLK) begin
    if (NEW_IMAGE) begin
      nimg++;
      if (jobs.size() > 0) cur = jobs.pop_front();
      else begin cur.delay = 0; cur.digit = 0; end
      ENCODER_RDY   = 1'b0;
      DECODER_RDY   = ($urandom_range(1) == 0);
      INFERED_DIGIT = M'(cur.digit + 3);
      cd            = cur.delay;
    end else if (cd > 1) begin
      cd--;
      if (cd == 1) begin
        INFERED_DIGIT = M'(cur.digit);
        ENCODER_RDY   = 1'b1;
        DECODER_RDY   = 1'b1;
        cd            = 0;
      end
    end
  end

  // ---------------- result consumer ----------------
  logic          pop_en  = 1'b0;
  int            pop_pct = 100;
  logic [RW-1:0] got[$];

  always @(negedge CLK) begin
    if (pop_en && ($urandom_range(99) < pop_pct)) begin
      if (RES_VALID) got.push_back(RES_DATA);
      RES_POP = 1'b1;
    end else begin
      RES_POP = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] word_of(input int flag, input int digit, input int lat);
`ifdef SNN_SEQ_LATENCY_EN
    return {LB'(lat), 1'(flag), M'(digit)};
`else
    if (lat < 0) return '0;
    return {1'(flag), M'(digit)};
`endif
  endfunction

  // Completion is seen in RUN cycle delay-1; it must land within TMO cycles.
  function automatic logic [RW-1:0] model_word(input int delay, input int digit);
    bit to;
    to = (delay == 0) || (delay - 1 > TMO);
    return word_of(to ? 1 : 0, to ? 0 : digit, to ? TMO : delay - 1);
  endfunction

  function automatic bit model_to(input int delay);
    return (delay == 0) || (delay - 1 > TMO);
  endfunction

  // ---------------- helpers ----------------
  task automatic start_batch(input int len);
    @(negedge CLK);
    BATCH_LEN = BB'(len);
    START     = 1'b1;
    @(negedge CLK);
    START     = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int i = 0;
    while (!IRQ && i < budget) begin @(negedge CLK); i++; end
    chk("irq_wait", IRQ, 1);
  endtask

  task automatic wait_nimg(input int target, input int budget);
    int i = 0;
    while (nimg < target && i < budget) begin @(negedge CLK); i++; end
    chk("nimg_wait", nimg, target);
  endtask

  task automatic wait_got(input int n, input int budget);
    int i = 0;
    while (got.size() < n && i < budget) begin @(negedge CLK); i++; end
    chk("result_count", got.size(), n);
  endtask

  task automatic cmp_results(input string nm, input logic [RW-1:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk(nm, got[i], exp[i]);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct { int delay; int digit; int exp_flag; int exp_digit; } vec_t;
  vec_t tbl[8];

  logic [RW-1:0] expq[$];

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bstart[2];
    int blen[2];
    int len;
    int i;
    bit to_any;
    job_t j;

    tbl[0] = '{50, 7, 0, 7};
    tbl[1] = '{50, 2, 0, 2};
    tbl[2] = '{50, 9, 0, 9};
    tbl[3] = '{3, 5, 0, 5};     // fastest legal completion
    tbl[4] = '{65, 12, 0, 12};  // completion in the timeout cycle wins
    tbl[5] = '{66, 4, 1, 0};    // one cycle too late: timeout
    tbl[6] = '{0, 8, 1, 0};     // ready never returns
    tbl[7] = '{30, 15, 0, 15};
    bstart = '{0, 3};
    blen   = '{3, 5};

    // ---- reset state ----
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_irq", IRQ, 0);
    chk("rst_valid", RES_VALID, 0);
    chk("rst_count", RES_COUNT, 0);
    chk("rst_data", RES_DATA, 0);
    chk("rst_done", DONE_COUNT, 0);
    chk("rst_terr", TIMEOUT_ERR, 0);
    chk("rst_newimg", NEW_IMAGE, 0);

    // ---- START with zero length is ignored ----
    start_batch(0);
    repeat (3) @(negedge CLK);
    chk("len0_busy", BUSY, 0);
    chk("len0_nimg", nimg, 0);

    // ---- table batches ----
    pop_en = 1'b1; pop_pct = 100;
    for (int b = 0; b < 2; b++) begin
      got.delete(); expq.delete();
      base = nimg;
      for (int k = bstart[b]; k < bstart[b] + blen[b]; k++) begin
        j.delay = tbl[k].delay; j.digit = tbl[k].digit;
        jobs.push_back(j);
        expq.push_back(word_of(tbl[k].exp_flag, tbl[k].exp_digit,
                               tbl[k].exp_flag != 0 ? TMO : tbl[k].delay - 1));
      end
      start_batch(blen[b]);
      if (b == 0) begin
        wait_irq(1000);
        chk("a_busy", BUSY, 0);
        chk("a_terr", TIMEOUT_ERR, 0);
      end else begin
        chk("irq_clr_by_start", IRQ, 0);
        IRQ_CLR = 1'b1;
        wait_nimg(base + blen[b], 1000);
        i = 0;
        while (BUSY && i < 1000) begin @(negedge CLK); i++; end
        chk("irq_set_wins", IRQ, 1);
        @(negedge CLK);
        chk("irq_clr", IRQ, 0);
        IRQ_CLR = 1'b0;
        chk("b_terr", TIMEOUT_ERR, 1);
      end
      chk("tbl_done", DONE_COUNT, blen[b]);
      chk("tbl_nimg", nimg - base, blen[b]);
      wait_got(blen[b], 100);
      cmp_results("tbl_result", expq);
    end

    // ---- back-pressure: 6 images, FIFO of 4, no pops ----
    pop_en = 1'b0;
    repeat (2) @(negedge CLK);
    got.delete(); expq.delete();
    base = nimg;
    for (int k = 0; k < 6; k++) begin
      j.delay = 5; j.digit = k + 1;
      jobs.push_back(j);
      expq.push_back(model_word(j.delay, j.digit));
    end
    start_batch(6);
    wait_nimg(base + 5, 500);
    repeat (40) @(negedge CLK);
    chk("bp_count", RES_COUNT, DEP);
    chk("bp_busy", BUSY, 1);
    chk("bp_done", DONE_COUNT, 4);
    chk("bp_nimg", nimg - base, 5);
    chk("bp_head", RES_DATA, expq[0]);
    pop_en = 1'b1; pop_pct = 100;
    wait_irq(500);
    wait_got(6, 100);
    cmp_results("bp_result", expq);
    chk("bp_done_end", DONE_COUNT, 6);

    // ---- ABORT during RUN of image 2 of 5 ----
    pop_en = 1'b0;
    repeat (2) @(negedge CLK);
    got.delete(); expq.delete();
    base = nimg;
    for (int k = 0; k < 5; k++) begin
      j.delay = 20; j.digit = 10 + k;
      jobs.push_back(j);
    end
    expq.push_back(model_word(20, 10));
    start_batch(5);
    wait_nimg(base + 2, 500);
    repeat (5) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE_COUNT, 1);
    chk("abort_count", RES_COUNT, 1);
    chk("abort_irq", IRQ, 0);
    jobs.delete();
    repeat (30) @(negedge CLK);
    chk("abort_nimg", nimg - base, 2);
    chk("abort_irq_late", IRQ, 0);
    pop_en = 1'b1;
    wait_got(1, 50);
    cmp_results("abort_result", expq);
    got.delete(); expq.delete();
    base = nimg;
    j.delay = 10; j.digit = 6; jobs.push_back(j); expq.push_back(model_word(10, 6));
    j.delay = 4;  j.digit = 1; jobs.push_back(j); expq.push_back(model_word(4, 1));
    start_batch(2);
    wait_irq(500);
    chk("restart_done", DONE_COUNT, 2);
    wait_got(2, 100);
    cmp_results("restart_result", expq);

    // ---- randomized batches against the model ----
    for (int r = 0; r < 6; r++) begin
      got.delete(); expq.delete();
      len = $urandom_range(7, 1);
      pop_pct = $urandom_range(100, 20);
      to_any = 1'b0;
      for (int k = 0; k < len; k++) begin
        j.delay = ($urandom_range(9) == 0) ? 0 : $urandom_range(75, 3);
        j.digit = $urandom_range(15);
        jobs.push_back(j);
        expq.push_back(model_word(j.delay, j.digit));
        to_any |= model_to(j.delay);
      end
      start_batch(len);
      wait_irq(3000);
      chk("rnd_done", DONE_COUNT, len);
      chk("rnd_terr", TIMEOUT_ERR, to_any);
      wait_got(len, 500);
      cmp_results("rnd_result", expq);
      @(negedge CLK); IRQ_CLR = 1'b1;
      @(negedge CLK); IRQ_CLR = 1'b0;
      chk("rnd_irq_clr", IRQ, 0);
    end

    // ---- reset in the middle of a batch flushes everything ----
    pop_en = 1'b0;
    repeat (2) @(negedge CLK);
    base = nimg;
    for (int k = 0; k < 4; k++) begin
      j.delay = 6; j.digit = k; jobs.push_back(j);
    end
    start_batch(4);
    wait_nimg(base + 3, 500);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    jobs.delete();
    chk("mrst_count", RES_COUNT, 0);
    chk("mrst_valid", RES_VALID, 0);
    chk("mrst_data", RES_DATA, 0);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_done", DONE_COUNT, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
